// File: rtl/bcd_display_scanner.sv
// Three-digit multiplexed common-anode 7-segment scanner with dead time and frame tick.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_display_scanner #(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 2,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [1:0] hundreds,
  output logic [2:0] an_n,
  output logic [6:0] seg_n,
  output logic       frame_tick
);

  typedef enum logic [1:0] {SLOT_ONES, SLOT_TENS, SLOT_HUND, SLOT_BAD} slot_t;

  slot_t            slot, slot_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       ones_q, tens_q;
  logic [1:0]       hund_q;
  logic [3:0]       digit;
  logic [2:0]       sel, an_d;
  logic [6:0]       seg_d;
  logic             wrap, blank, lit, tick_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111; // invalid BCD shows a dash
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      slot   <= SLOT_ONES;
      ones_q <= '0;
      tens_q <= '0;
      hund_q <= '0;
    end else begin
      cnt  <= cnt_nxt;
      slot <= slot_nxt;
      if (load) begin
        ones_q <= ones;
        tens_q <= tens;
        hund_q <= hundreds;
      end
    end
  end

  always_comb begin
    wrap     = (cnt == CNT_W'(PRESCALE - 1));
    cnt_nxt  = wrap ? '0 : cnt + CNT_W'(1);
    slot_nxt = slot;
    tick_d   = 1'b0;
    if (wrap) begin
      case (slot)
        SLOT_ONES: slot_nxt = SLOT_TENS;
        SLOT_TENS: slot_nxt = SLOT_HUND;
        SLOT_HUND: begin
          slot_nxt = SLOT_ONES;
          tick_d   = 1'b1;
        end
        default:   slot_nxt = SLOT_ONES;
      endcase
    end
    // An unreachable slot value is forced back to ones without lighting anything.
    if (slot == SLOT_BAD) slot_nxt = SLOT_ONES;
  end

  always_comb begin
    digit = ones_q;
    sel   = 3'b111;
    case (slot)
      SLOT_ONES: begin digit = ones_q;          sel = 3'b110; end
      SLOT_TENS: begin digit = tens_q;          sel = 3'b101; end
      SLOT_HUND: begin digit = {2'b00, hund_q}; sel = 3'b011; end
      default:   begin digit = ones_q;          sel = 3'b111; end
    endcase
`ifdef BCD_SCAN_LZB_EN
    blank = ((slot == SLOT_HUND) && (hund_q == 2'd0)) ||
            ((slot == SLOT_TENS) && (hund_q == 2'd0) && (tens_q == 4'd0));
`else
    blank = 1'b0;
`endif
    lit   = (cnt >= CNT_W'(DEAD)) && !blank && (sel != 3'b111);
    an_d  = 3'b111;
    seg_d = 7'b1111111;
    if (lit) begin
      an_d  = sel;
      seg_d = seg_decode(digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= 3'b111;
      seg_n      <= 7'b1111111;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= an_d;
      seg_n      <= seg_d;
      frame_tick <= tick_d;
    end
  end

endmodule
